// File: rtl/moda_collector.sv
`default_nettype none
// ============================================================================
// moda_collector
//   Round-robin responder for NUM_SRC moda requesters. Each capture pushes a
//   {src,data} entry into a FIFO that drains over a valid/ready stream.
//   Optional capture counter: define MODA_COLLECTOR_STAT_EN.
// Revision: 1.0
// ============================================================================
module moda_collector #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 4,
    parameter int SRC_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     src_en,
    input  logic [NUM_SRC-1:0]     src_o1,
    input  logic [2*NUM_SRC-1:0]   src_o2,
    output logic [NUM_SRC-1:0]     src_i1,
    output logic [NUM_SRC-1:0]     src_i2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SRC_W-1:0]       out_src,
    output logic [1:0]             out_data,
    output logic [15:0]            cap_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_ENT_W = SRC_W + 2;
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
    localparam logic [SRC_W:0]     c_NUM      = (SRC_W + 1)'(NUM_SRC);
    localparam logic [NUM_SRC-1:0] c_ONE_HOT0 = NUM_SRC'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t                r_state;
    logic [NUM_SRC-1:0]    r_src_i1;
    logic [NUM_SRC-1:0]    r_src_i2;
    logic [SRC_W-1:0]      r_rr;

    logic [c_ENT_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr;
    logic [c_PTR_W-1:0]    r_rd;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_out_valid;
    logic [SRC_W-1:0]      r_out_src;
    logic [1:0]            r_out_data;

    logic [NUM_SRC-1:0]    w_elig;
    logic                  w_full;
    logic                  w_gnt_found;
    logic [SRC_W-1:0]      w_gnt_idx;
    logic [SRC_W-1:0]      w_rr_next;
    logic                  w_push;
    logic                  w_pop;
    logic [c_ENT_W-1:0]    w_push_ent;
    logic [c_ENT_W-1:0]    w_head_ent;
    logic [c_CNT_W-1:0]    w_cnt_next;
    logic [c_PTR_W-1:0]    w_rd_next;
    logic [1:0]            w_payload [NUM_SRC];

    function automatic logic [SRC_W-1:0] f_wrap(input logic [SRC_W:0] v);
        f_wrap = (v >= c_NUM) ? SRC_W'(v - c_NUM) : SRC_W'(v);
    endfunction

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_payload
        assign w_payload[g] = src_o2[2*g +: 2];
    end

    assign w_elig = src_o1 & r_src_i2 & ~r_src_i1;
    assign w_full = (r_count == c_DEPTH);

    // Scan from the highest offset down so the lowest offset from r_rr wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_elig[f_wrap({1'b0, r_rr} + (SRC_W + 1)'(k))]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = f_wrap({1'b0, r_rr} + (SRC_W + 1)'(k));
            end
        end
    end

    assign w_rr_next  = f_wrap({1'b0, w_gnt_idx} + (SRC_W + 1)'(1));
    assign w_push     = (r_state == S_IDLE) && w_gnt_found && !w_full;
    assign w_pop      = r_out_valid && out_ready;
    assign w_push_ent = {w_gnt_idx, w_payload[w_gnt_idx]};

    assign w_cnt_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_rd_next  = r_rd + c_PTR_W'(w_pop);
    // When nothing older survives this edge, the new head is the entry being pushed.
    assign w_head_ent = ((r_count - c_CNT_W'(w_pop)) == '0) ? w_push_ent : r_mem[w_rd_next];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_src_i1 <= '0;
            r_src_i2 <= '0;
            r_rr     <= '0;
        end else begin
            r_src_i2 <= src_en & ~{NUM_SRC{w_full}};
            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_src_i1 <= c_ONE_HOT0 << w_gnt_idx;
                        r_rr     <= w_rr_next;
                        r_state  <= S_ACK;
                    end else begin
                        r_src_i1 <= '0;
                    end
                end
                S_ACK: begin
                    r_src_i1 <= '0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_src_i1 <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_push_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_out_data  <= '0;
        end else begin
            r_wr        <= r_wr + c_PTR_W'(w_push);
            r_rd        <= w_rd_next;
            r_count     <= w_cnt_next;
            r_out_valid <= (w_cnt_next != '0);
            if (w_cnt_next != '0) begin
                {r_out_src, r_out_data} <= w_head_ent;
            end
        end
    end

`ifdef MODA_COLLECTOR_STAT_EN
    logic [15:0] r_cap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_cnt <= '0;
        end else if (w_push && (r_cap_cnt != 16'hFFFF)) begin
            r_cap_cnt <= r_cap_cnt + 16'd1;
        end
    end

    assign cap_cnt = r_cap_cnt;
`else
    assign cap_cnt = 16'h0000;
`endif

    assign src_i1    = r_src_i1;
    assign src_i2    = r_src_i2;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire
